// File: rtl/approx_mul_accumulator.sv
// Windowed saturating accumulator for approximate-multiplier products.
// Sums one 16-bit product per accepted beat and hands the window result to a valid/ready consumer.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACCUM | accepting product beats, in_ready=1 (after the first clock out of reset)
// HOLD  | window result presented, out_valid=1, waiting for out_ready
module approx_mul_accumulator #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    input  logic             in_last,
    input  logic [CNT_W-1:0] len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;
    logic             sat;

    logic             accept;
    logic [ACC_W:0]   sum_w;
    logic [ACC_W-1:0] acc_upd;
    logic             sat_upd;
    logic [CNT_W-1:0] cnt_upd;
    logic [CNT_W-1:0] len_eff;
    logic             close;

    always_comb begin
        accept  = in_valid && in_ready;
        sum_w   = {1'b0, acc} + (ACC_W+1)'(in_prod);
        sat_upd = sat | sum_w[ACC_W];
        acc_upd = sat_upd ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
        cnt_upd = cnt + CNT_W'(1);
        // the first beat of a window has not latched len yet, so compare against the live port
        len_eff = (cnt == '0) ? len : len_q;
        close   = in_last
                || ((len_eff != '0) && (cnt_upd == len_eff))
                || (cnt_upd == CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            len_q     <= '0;
            out_sum   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (cnt == '0) len_q <= len;
                        acc <= acc_upd;
                        sat <= sat_upd;
                        cnt <= cnt_upd;
                        if (close) begin
                            out_sum   <= acc_upd;
                            out_count <= cnt_upd;
                            out_sat   <= sat_upd;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc       <= '0;
                        cnt       <= '0;
                        sat       <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mul_accumulator.sv
// Bench for approx_mul_accumulator: a 24-bit and a 17-bit instance share the same stimulus.
`timescale 1ns/1ps
module tb_approx_mul_accumulator;

    localparam int CNT_W = 8;
    localparam longint MAX24 = 64'd16777215;
    localparam longint MAX17 = 64'd131071;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [15:0]      in_prod = '0;
    logic             in_last = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             out_ready = 1'b1;

    logic             in_ready, out_valid, out_sat;
    logic [23:0]      out_sum;
    logic [CNT_W-1:0] out_count;
    logic             in_ready17, out_valid17, out_sat17;
    logic [16:0]      out_sum17;
    logic [CNT_W-1:0] out_count17;

    int total = 0;
    int bad = 0;

    approx_mul_accumulator #(.ACC_W(24), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .in_last(in_last), .len(len),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_sat(out_sat));

    approx_mul_accumulator #(.ACC_W(17), .CNT_W(CNT_W)) dut17 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready17),
        .in_prod(in_prod), .in_last(in_last), .len(len),
        .out_valid(out_valid17), .out_ready(out_ready),
        .out_sum(out_sum17), .out_count(out_count17), .out_sat(out_sat17));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int len; int n; int base; int stp; int last;
        int e_sum; int e_cnt; int e_sat; int e_sum17; int e_sat17;
    } vec_t;

    vec_t vt[8];

    task automatic run_window(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            in_valid = 1'b1;
            in_prod  = 16'(v.base + i * v.stp);
            in_last  = (v.last != 0) && (i == v.n - 1);
            len      = CNT_W'(v.len);
            if (i == v.n - 1) begin
                chk("pre_close_ready", in_ready, 1);
                chk("pre_close_valid", out_valid, 0);
            end
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("win_out_valid", out_valid, 1);
        chk("win_in_ready", in_ready, 0);
        chk("win_sum", out_sum, v.e_sum);
        chk("win_count", out_count, v.e_cnt);
        chk("win_sat", out_sat, v.e_sat);
        chk("win_sum17", out_sum17, v.e_sum17);
        chk("win_sat17", out_sat17, v.e_sat17);
        step();
        chk("post_hs_valid", out_valid, 0);
        chk("post_hs_ready", in_ready, 1);
    endtask

    // soak reference model state
    longint m_sum24, m_sum17;
    int     m_cnt, m_len;
    bit     m_sat24, m_sat17;
    longint q_sum24[$], q_sum17[$];
    int     q_cnt[$];
    bit     q_sat24[$], q_sat17[$];

    initial begin
        vt[0] = '{4, 4, 100, 100, 0, 1000, 4, 0, 1000, 0};
        vt[1] = '{10, 3, 65535, 0, 1, 196605, 3, 0, 131071, 1};
        vt[2] = '{0, 1, 7, 0, 1, 7, 1, 0, 7, 0};
        vt[3] = '{0, 4, 65535, 0, 1, 262140, 4, 0, 131071, 1};
        vt[4] = '{2, 2, 5, 1, 0, 11, 2, 0, 11, 0};
        vt[5] = '{3, 3, 10, 0, 1, 30, 3, 0, 30, 0};
        vt[6] = '{1, 1, 65535, 0, 0, 65535, 1, 0, 65535, 0};
        vt[7] = '{5, 5, 1000, 0, 0, 5000, 5, 0, 5000, 0};

        // reset values and first-clock readiness
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        #20;
        rst = 1'b0;
        #1;
        chk("rel_in_ready_before_clk", in_ready, 0);
        step();
        chk("rel_in_ready_after_clk", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);

        for (int k = 0; k < 8; k++) run_window(vt[k]);

        // asynchronous reset in the middle of a window
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_prod = 16'd50; len = 8'd8; in_last = 1'b0;
            step();
        end
        in_valid = 1'b0;
        chk("mid_no_close", out_valid, 0);
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_out_sum", out_sum, 0);
        chk("arst_out_count", out_count, 0);
        chk("arst_out_sum17", out_sum17, 0);
        #3 rst = 1'b0;
        step();
        chk("arst_rel_ready", in_ready, 1);
        run_window('{2, 2, 5, 1, 0, 11, 2, 0, 11, 0});

        // forced close at 255 beats with len=0, then backpressure
        begin
            int acc_n;
            acc_n = 0;
            out_ready = 1'b0;
            in_valid = 1'b1; in_prod = 16'd1; in_last = 1'b0; len = '0;
            for (int c = 0; c < 300 && !out_valid; c++) begin
                if (in_ready) acc_n++;
                step();
                if (acc_n == 255) begin
                    in_prod = 16'd9;
                    in_last = 1'b1;
                end
            end
            chk("forced_accepts", acc_n, 255);
            chk("forced_valid", out_valid, 1);
            chk("forced_count", out_count, 255);
            chk("forced_sum", out_sum, 255);
            chk("forced_sat", out_sat, 0);
            for (int c = 0; c < 5; c++) begin
                step();
                chk("bp_valid", out_valid, 1);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_sum", out_sum, 255);
                chk("bp_count", out_count, 255);
            end
            out_ready = 1'b1;
            step();
            chk("bp_hs_valid", out_valid, 0);
            chk("bp_hs_ready", in_ready, 1);
            step();
            in_valid = 1'b0; in_last = 1'b0;
            chk("held_beat_valid", out_valid, 1);
            chk("held_beat_sum", out_sum, 9);
            chk("held_beat_count", out_count, 1);
            step();
            chk("held_beat_hs", out_valid, 0);
        end

        // random soak against a window-level reference model
        begin
            int accepts, windows, cyc;
            bit hs, acc;
            accepts = 0; windows = 0; cyc = 0;
            m_sum24 = 0; m_sum17 = 0; m_cnt = 0; m_len = 0; m_sat24 = 0; m_sat17 = 0;
            while (accepts < 10000 && cyc < 40000) begin
                cyc++;
                if (out_valid !== (q_cnt.size() != 0)) begin
                    chk("soak_out_valid", out_valid, q_cnt.size() != 0);
                end
                if (!(in_valid && !in_ready)) begin
                    in_valid = ($urandom_range(3) != 0);
                    in_prod  = ($urandom_range(1) != 0) ? 16'($urandom_range(65535))
                                                        : 16'($urandom_range(65535, 60000));
                    in_last  = ($urandom_range(7) == 0);
                    len      = ($urandom_range(15) == 0) ? CNT_W'($urandom_range(255))
                                                         : CNT_W'($urandom_range(9));
                end
                out_ready = ($urandom_range(2) != 0);
                hs  = out_valid && out_ready;
                acc = in_valid && in_ready;
                if (hs) begin
                    if (q_cnt.size() == 0) begin
                        chk("soak_unexpected_result", 1, 0);
                    end else begin
                        chk("soak_sum", out_sum, q_sum24.pop_front());
                        chk("soak_sum17", out_sum17, q_sum17.pop_front());
                        chk("soak_count", out_count, q_cnt.pop_front());
                        chk("soak_sat", out_sat, q_sat24.pop_front());
                        chk("soak_sat17", out_sat17, q_sat17.pop_front());
                        windows++;
                    end
                end
                if (acc) begin
                    accepts++;
                    if (m_cnt == 0) m_len = int'(len);
                    m_sum24 += longint'(in_prod);
                    m_sum17 += longint'(in_prod);
                    if (m_sum24 > MAX24) begin m_sum24 = MAX24; m_sat24 = 1; end
                    if (m_sum17 > MAX17) begin m_sum17 = MAX17; m_sat17 = 1; end
                    m_cnt++;
                    if (in_last || (m_len != 0 && m_cnt == m_len) || m_cnt == 255) begin
                        q_sum24.push_back(m_sum24);
                        q_sum17.push_back(m_sum17);
                        q_cnt.push_back(m_cnt);
                        q_sat24.push_back(m_sat24);
                        q_sat17.push_back(m_sat17);
                        m_sum24 = 0; m_sum17 = 0; m_cnt = 0; m_sat24 = 0; m_sat17 = 0;
                    end
                end
                step();
            end
            chk("soak_accepts", accepts, 10000);
            chk("soak_windows_seen", windows > 100, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
